// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, S-box table, GF(2^8) xtime and the key-schedule state type.
package aes_pkg;

  localparam int NR = 10;
  localparam int KW = 128;
  localparam logic [3:0] LAST_IDX = 4'(NR);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} ks_state_e;

  // One generated round key as it leaves the schedule.
  typedef struct packed {
    logic          valid;
    logic [3:0]    idx;
    logic [KW-1:0] key;
  } gen_t;

  localparam logic [7:0] AES_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return AES_SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Control/data bundle between the key schedule (slave) and its consumer (master).
interface aes_key_schedule_if;
  import aes_pkg::*;

  logic          start;
  logic [KW-1:0] key;
  logic          keyReady;
  logic          genValid;
  logic [3:0]    genIdx;
  logic [KW-1:0] genKey;
  logic [3:0]    rdIdx;
  logic [KW-1:0] roundKey;

  modport master (
    output start, key, rdIdx,
    input  keyReady, genValid, genIdx, genKey, roundKey
  );

  modport slave (
    input  start, key, rdIdx,
    output keyReady, genValid, genIdx, genKey, roundKey
  );

endinterface

// File: rtl/aes_sbox.sv
// 8-bit combinational AES S-box; shared by the key schedule and the cipher datapath.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = sbox(a);

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: one round key per cycle into an 11-entry bank,
// streamed out as generated, with a registered random-access read port.
module aes_key_schedule
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  aes_key_schedule_if.slave bus
);

  ks_state_e     state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    rcon_q, rcon_d;
  logic          ready_q, ready_d;
  gen_t          gen_q, gen_d;
  logic [KW-1:0] rd_q, rd_d;
  logic [KW-1:0] bank_q [NR+1];
  logic [KW-1:0] bank_d [NR+1];

  // gen_q.key doubles as the previous round key feeding the next expansion step.
  logic [31:0]   w3_rot, w3_sub, temp;
  logic [31:0]   w4, w5, w6, w7;
  logic [KW-1:0] next_key;

  assign w3_rot = {gen_q.key[23:0], gen_q.key[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .a (w3_rot[8*b +: 8]),
      .y (w3_sub[8*b +: 8])
    );
  end

  assign temp     = w3_sub ^ {rcon_q, 24'h0};
  assign w4       = gen_q.key[127:96] ^ temp;
  assign w5       = gen_q.key[95:64]  ^ w4;
  assign w6       = gen_q.key[63:32]  ^ w5;
  assign w7       = gen_q.key[31:0]   ^ w6;
  assign next_key = {w4, w5, w6, w7};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rcon_d    = rcon_q;
    ready_d   = ready_q;
    gen_d     = gen_q;
    gen_d.valid = 1'b0;
    bank_d    = bank_q;
    rd_d      = '0;
    // Read sees pre-edge bank contents: no write bypass.
    if (bus.rdIdx <= LAST_IDX) rd_d = bank_q[bus.rdIdx];

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          bank_d[0] = bus.key;
          gen_d     = '{valid: 1'b1, idx: 4'd0, key: bus.key};
          ready_d   = 1'b0;
          cnt_d     = 4'd1;
          rcon_d    = 8'h01;
          state_d   = EXPAND;
        end
      end
      EXPAND: begin
        bank_d[cnt_q] = next_key;
        gen_d   = '{valid: 1'b1, idx: cnt_q, key: next_key};
        cnt_d   = cnt_q + 4'd1;
        rcon_d  = xtime(rcon_q);
        if (cnt_q == LAST_IDX) begin
          state_d = DONE;
          ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rcon_q  <= 8'h01;
      ready_q <= 1'b0;
      gen_q   <= '0;
      rd_q    <= '0;
      for (int i = 0; i <= NR; i++) bank_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcon_q  <= rcon_d;
      ready_q <= ready_d;
      gen_q   <= gen_d;
      rd_q    <= rd_d;
      bank_q  <= bank_d;
    end
  end

  assign bus.keyReady = ready_q;
  assign bus.genValid = gen_q.valid;
  assign bus.genIdx   = gen_q.idx;
  assign bus.genKey   = gen_q.key;
  assign bus.roundKey = rd_q;

endmodule
